// File: rtl/motor_drive_ctrl.sv
// Multi-channel H-bridge motor controller: per-channel duty ramping,
// dead-time braking on direction reversal and a global obstacle stop.
module motor_drive_ctrl #(
    parameter int N_CH       = 2,
    parameter int PWM_W      = 10,
    parameter int RAMP_DIV   = 1000,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic             cmd_dir,
    input  logic [PWM_W-1:0] cmd_duty,
    output logic [N_CH-1:0]  pwm_en,
    output logic [N_CH-1:0]  in_a,
    output logic [N_CH-1:0]  in_b,
    output logic [N_CH-1:0]  busy
);

    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DT     = (DEAD_TICKS > 1) ? DEAD_TICKS : 1;
    localparam int DEAD_W = (DT > 1) ? $clog2(DT) : 1;
    localparam int STEP_C = (RAMP_STEP < 2**PWM_W) ? RAMP_STEP : 2**PWM_W;

    localparam logic [PWM_W:0]    STEP      = (PWM_W+1)'(STEP_C);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        BRAKE = 2'd3
    } state_t;

    logic [PWM_W-1:0] cnt;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             accept;

    assign cmd_ready = rst & ~stop;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            pre <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            st;
        state_t            st_n;
        logic [PWM_W-1:0]  cur;
        logic [PWM_W-1:0]  cur_n;
        logic [PWM_W-1:0]  tgt;
        logic [PWM_W-1:0]  tgt_n;
        logic [PWM_W-1:0]  aim;
        logic [PWM_W-1:0]  step_v;
        logic [PWM_W:0]    up;
        logic [PWM_W:0]    dn;
        logic [DEAD_W-1:0] dead;
        logic [DEAD_W-1:0] dead_n;
        logic              cdir;
        logic              cdir_n;
        logic              tdir;
        logic              tdir_n;
        logic              hit;
        logic              pwm_q;
        logic              out_a;
        logic              out_b;
        logic              out_busy;

        assign hit = accept && (cmd_ch == CH_W'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st   <= IDLE;
                cur  <= '0;
                tgt  <= '0;
                dead <= '0;
                cdir <= 1'b1;
                tdir <= 1'b1;
            end else begin
                st   <= st_n;
                cur  <= cur_n;
                tgt  <= tgt_n;
                dead <= dead_n;
                cdir <= cdir_n;
                tdir <= tdir_n;
            end
        end

        // A pending reversal ramps toward zero before the brake phase.
        always_comb begin
            aim = (tdir != cdir) ? '0 : tgt;
            up  = {1'b0, cur} + STEP;
            dn  = {1'b0, cur} - STEP;
            if ({1'b0, cur} < {1'b0, aim})
                step_v = (up >= {1'b0, aim}) ? aim : up[PWM_W-1:0];
            else
                step_v = ({1'b0, cur} <= {1'b0, aim} + STEP) ? aim : dn[PWM_W-1:0];
        end

        always_comb begin
            st_n   = st;
            cur_n  = cur;
            tgt_n  = tgt;
            tdir_n = tdir;
            cdir_n = cdir;
            dead_n = dead;
            if (stop) begin
                st_n   = BRAKE;
                cur_n  = '0;
                tgt_n  = '0;
                dead_n = '0;
            end else begin
                if (hit) begin
                    tgt_n  = cmd_duty;
                    tdir_n = cmd_dir;
                end
                unique case (st)
                    IDLE: begin
                        if (hit && cmd_duty != '0) begin
                            cdir_n = cmd_dir;
                            st_n   = RAMP;
                        end else if (tgt != '0) begin
                            cdir_n = tdir;
                            st_n   = RAMP;
                        end
                    end
                    RAMP: begin
                        if (tick) begin
                            cur_n = step_v;
                            if (step_v == aim) begin
                                if (tdir != cdir) begin
                                    st_n   = BRAKE;
                                    dead_n = '0;
                                end else if (tgt == '0) begin
                                    st_n = IDLE;
                                end else begin
                                    st_n = RUN;
                                end
                            end
                        end
                    end
                    RUN: begin
                        if (tgt != cur || tdir != cdir)
                            st_n = RAMP;
                    end
                    BRAKE: begin
                        if (tick) begin
                            if (dead == DEAD_LAST) begin
                                dead_n = '0;
                                if (tgt != '0) begin
                                    cdir_n = tdir;
                                    st_n   = RAMP;
                                end else begin
                                    st_n = IDLE;
                                end
                            end else begin
                                dead_n = dead + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        always_comb begin
            out_a    = 1'b0;
            out_b    = 1'b0;
            out_busy = 1'b0;
            unique case (st)
                IDLE: ;
                RAMP: begin
                    out_a    = cdir;
                    out_b    = ~cdir;
                    out_busy = 1'b1;
                end
                RUN: begin
                    out_a = cdir;
                    out_b = ~cdir;
                end
                BRAKE: out_busy = 1'b1;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                pwm_q <= 1'b0;
            else
                pwm_q <= (cur > cnt);
        end

        assign pwm_en[i] = pwm_q;
        assign in_a[i]   = out_a;
        assign in_b[i]   = out_b;
        assign busy[i]   = out_busy;
    end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Scoreboard bench for motor_drive_ctrl: expected duty ramps are queued
// at command time and popped as each channel's duty changes.
module tb_motor_drive_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stop;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [0:0] cmd_ch;
    logic       cmd_dir;
    logic [3:0] cmd_duty;
    logic [1:0] pwm_en;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic [1:0] busy;

    logic       cmd_valid3;
    logic       cmd_ready3;
    logic [1:0] cmd_ch3;
    logic [2:0] pwm_en3;
    logic [2:0] in_a3;
    logic [2:0] in_b3;
    logic [2:0] busy3;

    logic [3:0] cur0;
    logic [3:0] cur1;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];

    motor_drive_ctrl #(
        .N_CH(2), .PWM_W(4), .RAMP_DIV(2), .RAMP_STEP(4), .DEAD_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .stop(stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .pwm_en(pwm_en), .in_a(in_a), .in_b(in_b), .busy(busy)
    );

    motor_drive_ctrl #(
        .N_CH(3), .PWM_W(4), .RAMP_DIV(2), .RAMP_STEP(4), .DEAD_TICKS(2)
    ) dut3 (
        .clk(clk), .rst(rst), .stop(stop),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_ch(cmd_ch3), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .pwm_en(pwm_en3), .in_a(in_a3), .in_b(in_b3), .busy(busy3)
    );

    assign cur0 = dut.g_ch[0].cur;
    assign cur1 = dut.g_ch[1].cur;

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic ch, input logic dir, input logic [3:0] duty);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_dir   = dir;
        cmd_duty  = duty;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        stop       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        cmd_ch     = 1'b0;
        cmd_ch3    = 2'd0;
        cmd_dir    = 1'b0;
        cmd_duty   = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm_en, in_a, in_b, busy, cmd_ready} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b",
                     {pwm_en, in_a, in_b, busy, cmd_ready}, 9'b0);
        end
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_checks++;
            if ({pwm_en, in_a, in_b, busy, cmd_ready} !== 9'b000000001) begin
                n_fail++;
                $display("FAIL idle_outputs cycle %0d: got %b want %b", c,
                         {pwm_en, in_a, in_b, busy, cmd_ready}, 9'b000000001);
            end
        end
    endtask

    task automatic test_ramp();
        logic [3:0] last;
        int e;
        int hi;
        q0   = {4, 8, 10};
        last = cur0;
        send(1'b0, 1'b1, 4'd10);
        for (int c = 0; c < 60 && q0.size() > 0; c++) begin
            @(negedge clk);
            if (cur0 != last) begin
                e = q0.pop_front();
                n_checks++;
                if (cur0 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL ramp_cur: got %0d want %0d", cur0, e);
                end
                last = cur0;
            end
        end
        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL ramp_timeout: %0d values pending, want 0", q0.size());
            q0.delete();
        end
        n_checks++;
        if ({busy[0], in_a[0], in_b[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL ramp_run_state: got %b want 010", {busy[0], in_a[0], in_b[0]});
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_en[0]) hi++;
        end
        n_checks++;
        if (hi != 10) begin
            n_fail++;
            $display("FAIL ramp_pwm_high: got %0d want 10", hi);
        end
    endtask

    task automatic test_reverse();
        logic [3:0] last;
        int e;
        int brake;
        int hi;
        q0    = {6, 2, 0, 4, 6};
        brake = 0;
        last  = cur0;
        send(1'b0, 1'b0, 4'd6);
        for (int c = 0; c < 80 && q0.size() > 0; c++) begin
            @(negedge clk);
            if (busy[0] && !in_a[0] && !in_b[0]) brake++;
            if (cur0 != last) begin
                e = q0.pop_front();
                n_checks++;
                if (cur0 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL reverse_cur: got %0d want %0d", cur0, e);
                end
                last = cur0;
            end
        end
        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL reverse_timeout: %0d values pending, want 0", q0.size());
            q0.delete();
        end
        n_checks++;
        if (brake != 4) begin
            n_fail++;
            $display("FAIL reverse_brake_cycles: got %0d want 4", brake);
        end
        n_checks++;
        if ({busy[0], in_a[0], in_b[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL reverse_run_state: got %b want 001", {busy[0], in_a[0], in_b[0]});
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_en[0]) hi++;
        end
        n_checks++;
        if (hi != 6) begin
            n_fail++;
            $display("FAIL reverse_pwm_high: got %0d want 6", hi);
        end
    endtask

    task automatic test_stop();
        logic [3:0] last;
        int e;
        int b;
        int hi;
        q1   = {4, 8};
        last = cur1;
        send(1'b1, 1'b1, 4'd8);
        for (int c = 0; c < 60 && q1.size() > 0; c++) begin
            @(negedge clk);
            if (cur1 != last) begin
                e = q1.pop_front();
                n_checks++;
                if (cur1 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL stop_prep_cur: got %0d want %0d", cur1, e);
                end
                last = cur1;
            end
        end
        n_checks++;
        if (q1.size() != 0 || busy !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_prep_run: pending %0d busy %b want 0 and 00", q1.size(), busy);
            q1.delete();
        end
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ready: got %b want 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, in_a, in_b, cur0, cur1} !== {6'b110000, 8'd0}) begin
            n_fail++;
            $display("FAIL stop_brake: got %b want %b",
                     {busy, in_a, in_b, cur0, cur1}, {6'b110000, 8'd0});
        end
        b = 1;
        @(negedge clk);
        if (busy == 2'b11) b++;
        n_checks++;
        if (pwm_en !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_pwm_off: got %b want 00", pwm_en);
        end
        for (int c = 0; c < 20 && busy != 2'b00; c++) begin
            @(negedge clk);
            if (busy == 2'b11) b++;
        end
        n_checks++;
        if (b < 3 || b > 4 || {busy, in_a, in_b} !== 6'b0) begin
            n_fail++;
            $display("FAIL stop_to_idle: brake samples %0d outs %b want 3..4 and 000000",
                     b, {busy, in_a, in_b});
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_en != 2'b00) hi++;
        end
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL stop_idle_pwm: got %0d high cycles want 0", hi);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] last;
        int e;
        int hi;
        q0   = {4, 8, 12, 15};
        last = cur0;
        send(1'b0, 1'b1, 4'd15);
        for (int c = 0; c < 60 && q0.size() > 0; c++) begin
            @(negedge clk);
            if (cur0 != last) begin
                e = q0.pop_front();
                n_checks++;
                if (cur0 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL sat_cur: got %0d want %0d", cur0, e);
                end
                last = cur0;
            end
        end
        n_checks++;
        if (q0.size() != 0 || {busy[0], in_a[0], in_b[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL sat_run: pending %0d state %b want 0 and 010",
                     q0.size(), {busy[0], in_a[0], in_b[0]});
            q0.delete();
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_en[0]) hi++;
        end
        n_checks++;
        if (hi != 15) begin
            n_fail++;
            $display("FAIL sat_pwm_high: got %0d want 15", hi);
        end
        send(1'b1, 1'b0, 4'd0);
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if ({busy[1], in_a[1], in_b[1], cur1} !== 7'b0) begin
                n_fail++;
                $display("FAIL zero_duty_idle: got %b want 0", {busy[1], in_a[1], in_b[1], cur1});
            end
        end
        cmd_valid3 = 1'b1;
        cmd_ch3    = 2'd3;
        cmd_dir    = 1'b1;
        cmd_duty   = 4'd10;
        n_checks++;
        if (cmd_ready3 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch_ready: got %b want 1", cmd_ready3);
        end
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if ({busy3, in_a3, in_b3, pwm_en3} !== 12'b0) begin
                n_fail++;
                $display("FAIL bad_ch_ignored: got %b want 0", {busy3, in_a3, in_b3, pwm_en3});
            end
        end
        cmd_valid3 = 1'b1;
        cmd_ch3    = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy3 !== 3'b100) begin
            n_fail++;
            $display("FAIL good_ch_accept: got %b want 100", busy3);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] last0;
        logic [3:0] last1;
        int e;
        q1    = {4};
        q0    = {11, 7};
        last0 = cur0;
        last1 = cur1;
        cmd_valid = 1'b1;
        cmd_ch    = 1'b1;
        cmd_dir   = 1'b0;
        cmd_duty  = 4'd4;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_first: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_ch   = 1'b0;
        cmd_dir  = 1'b1;
        cmd_duty = 4'd7;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_second: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 60 && (q0.size() > 0 || q1.size() > 0); c++) begin
            @(negedge clk);
            if (cur0 != last0) begin
                e = (q0.size() > 0) ? q0.pop_front() : -1;
                n_checks++;
                if (cur0 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL b2b_cur0: got %0d want %0d", cur0, e);
                end
                last0 = cur0;
            end
            if (cur1 != last1) begin
                e = (q1.size() > 0) ? q1.pop_front() : -1;
                n_checks++;
                if (cur1 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL b2b_cur1: got %0d want %0d", cur1, e);
                end
                last1 = cur1;
            end
        end
        @(negedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0 || {busy, in_a, in_b} !== 6'b000110) begin
            n_fail++;
            $display("FAIL b2b_final: pending %0d/%0d outs %b want 0/0 and 000110",
                     q0.size(), q1.size(), {busy, in_a, in_b});
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] last;
        int e;
        send(1'b1, 1'b1, 4'd12);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pwm_en, in_a, in_b, busy, cmd_ready, cur1} !== 13'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b want 0",
                     {pwm_en, in_a, in_b, busy, cmd_ready, cur1});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwm_en, in_a, in_b, busy, cur0, cur1, cmd_ready} !== 17'b1) begin
            n_fail++;
            $display("FAIL midreset_release: got %b want %b",
                     {pwm_en, in_a, in_b, busy, cur0, cur1, cmd_ready}, 17'b1);
        end
        q1   = {4};
        last = cur1;
        send(1'b1, 1'b1, 4'd4);
        for (int c = 0; c < 40 && q1.size() > 0; c++) begin
            @(negedge clk);
            if (cur1 != last) begin
                e = q1.pop_front();
                n_checks++;
                if (cur1 !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL midreset_cur: got %0d want %0d", cur1, e);
                end
                last = cur1;
            end
        end
        n_checks++;
        if (q1.size() != 0 || {busy[1], in_a[1], in_b[1]} !== 3'b010) begin
            n_fail++;
            $display("FAIL midreset_run: pending %0d state %b want 0 and 010",
                     q1.size(), {busy[1], in_a[1], in_b[1]});
            q1.delete();
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reverse();
        test_stop();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
